// File: rtl/ccip_c0_rd_arbiter_if.sv
// Bus bundle between the DMA read engines, the MPF c0Tx port and the c0Rx
// response path, as seen by ccip_c0_rd_arbiter.
// slave  : the arbiter itself.
// master : the surrounding engines/MPF shim that drive requests and responses.
interface ccip_c0_rd_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
);
    // Requester side
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0][41:0]  req_addr;
    logic [NUM_REQ-1:0][1:0]   req_len;
    logic [NUM_REQ-1:0][11:0]  req_mdata;
    logic [NUM_REQ-1:0]        req_ready;

    // MPF c0Tx side
    logic                      c0_almfull;
    logic                      c0_valid;
    logic [41:0]               c0_addr;
    logic [1:0]                c0_len;
    logic [15:0]               c0_mdata;

    // c0Rx response in
    logic                      rsp_in_valid;
    logic [15:0]               rsp_in_mdata;
    logic [1:0]                rsp_in_cl_num;
    logic [511:0]              rsp_in_data;

    // Routed response out
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [11:0]               rsp_mdata;
    logic [1:0]                rsp_cl_num;
    logic [511:0]              rsp_data;

    modport slave (
        input  req_valid, req_addr, req_len, req_mdata,
        input  c0_almfull,
        input  rsp_in_valid, rsp_in_mdata, rsp_in_cl_num, rsp_in_data,
        output req_ready,
        output c0_valid, c0_addr, c0_len, c0_mdata,
        output rsp_valid, rsp_mdata, rsp_cl_num, rsp_data
    );

    modport master (
        output req_valid, req_addr, req_len, req_mdata,
        output c0_almfull,
        output rsp_in_valid, rsp_in_mdata, rsp_in_cl_num, rsp_in_data,
        input  req_ready,
        input  c0_valid, c0_addr, c0_len, c0_mdata,
        input  rsp_valid, rsp_mdata, rsp_cl_num, rsp_data
    );
endinterface

// File: rtl/ccip_c0_rd_arbiter.sv
// Round-robin arbiter sharing the CCI-P c0 (read) Tx path between NUM_REQ DMA
// read engines. Requests are tagged with the requester index in mdata[15:12]
// so c0Rx responses route back; a per-requester outstanding-line credit limit
// keeps one engine from starving the others.
// Optional build macro C0_RD_ARB_STATS_EN enables the almfull stall counter;
// when undefined stat_stall_cycles is tied to zero.
module ccip_c0_rd_arbiter #(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned MAX_OUTST = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    ccip_c0_rd_arbiter_if.slave   bus,
    output logic [31:0]           stat_stall_cycles
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0]          ptr_q, ptr_d;
    logic [NUM_REQ-1:0][8:0]   outst_q, outst_d;
    logic [NUM_REQ-1:0][2:0]   lines;
    logic [NUM_REQ-1:0]        elig;
    logic [NUM_REQ-1:0]        gnt_oh;
    logic [IDX_W-1:0]          gnt_idx;
    logic                      gnt_any;

    logic                      c0_valid_q, c0_valid_d;
    logic [41:0]               c0_addr_q, c0_addr_d;
    logic [1:0]                c0_len_q, c0_len_d;
    logic [15:0]               c0_mdata_q, c0_mdata_d;

    logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
    logic [11:0]               rsp_mdata_q, rsp_mdata_d;
    logic [1:0]                rsp_cl_num_q, rsp_cl_num_d;
    logic [511:0]              rsp_data_q, rsp_data_d;

    logic [3:0]                rsp_idx;

    assign rsp_idx = bus.rsp_in_mdata[15:12];

    // Line count per request and credit/almfull eligibility
    always_comb begin
        lines = '0;
        elig  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // cl_len 2 is illegal; charge it as a single line
            lines[i] = (bus.req_len[i] == 2'd2) ? 3'd1 : ({1'b0, bus.req_len[i]} + 3'd1);
            elig[i]  = bus.req_valid[i] && !bus.c0_almfull && !reset &&
                       (({1'b0, outst_q[i]} + 10'(lines[i])) <= 10'(MAX_OUTST));
        end
    end

    // Round-robin search starting at ptr, wrapping modulo NUM_REQ
    always_comb begin
        int unsigned idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt_oh  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!gnt_any && elig[IDX_W'(idx)]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'(idx);
            end
        end
        gnt_oh[gnt_idx] = gnt_any;
    end

    assign bus.req_ready = gnt_oh;

    // Pointer advances past the granted requester, holds otherwise
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

    // Outstanding-line accounting: +lines on grant, -1 per returned line, floor at 0
    always_comb begin
        logic [9:0] nxt;
        nxt     = '0;
        outst_d = outst_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            nxt = {1'b0, outst_q[i]} + (gnt_oh[i] ? 10'(lines[i]) : 10'd0);
            // A return with nothing outstanding is a protocol error; do not wrap
            if (bus.rsp_in_valid && (rsp_idx == 4'(i)) && (nxt != 10'd0)) begin
                nxt = nxt - 10'd1;
            end
            outst_d[i] = nxt[8:0];
        end
    end

    // Register the granted request toward MPF; data fields hold when idle
    always_comb begin
        c0_valid_d = gnt_any;
        c0_addr_d  = c0_addr_q;
        c0_len_d   = c0_len_q;
        c0_mdata_d = c0_mdata_q;
        if (gnt_any) begin
            c0_addr_d  = bus.req_addr[gnt_idx];
            c0_len_d   = bus.req_len[gnt_idx];
            c0_mdata_d = {4'(gnt_idx), bus.req_mdata[gnt_idx]};
        end
    end

    // Route responses by mdata[15:12]; out-of-range indices raise no valid
    always_comb begin
        rsp_valid_d  = '0;
        rsp_mdata_d  = rsp_mdata_q;
        rsp_cl_num_d = rsp_cl_num_q;
        rsp_data_d   = rsp_data_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.rsp_in_valid && (rsp_idx == 4'(i))) begin
                rsp_valid_d[i] = 1'b1;
            end
        end
        if (bus.rsp_in_valid) begin
            rsp_mdata_d  = bus.rsp_in_mdata[11:0];
            rsp_cl_num_d = bus.rsp_in_cl_num;
            rsp_data_d   = bus.rsp_in_data;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q        <= '0;
            outst_q      <= '0;
            c0_valid_q   <= 1'b0;
            c0_addr_q    <= '0;
            c0_len_q     <= '0;
            c0_mdata_q   <= '0;
            rsp_valid_q  <= '0;
            rsp_mdata_q  <= '0;
            rsp_cl_num_q <= '0;
            rsp_data_q   <= '0;
        end else begin
            ptr_q        <= ptr_d;
            outst_q      <= outst_d;
            c0_valid_q   <= c0_valid_d;
            c0_addr_q    <= c0_addr_d;
            c0_len_q     <= c0_len_d;
            c0_mdata_q   <= c0_mdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_mdata_q  <= rsp_mdata_d;
            rsp_cl_num_q <= rsp_cl_num_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign bus.c0_valid   = c0_valid_q;
    assign bus.c0_addr    = c0_addr_q;
    assign bus.c0_len     = c0_len_q;
    assign bus.c0_mdata   = c0_mdata_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_mdata  = rsp_mdata_q;
    assign bus.rsp_cl_num = rsp_cl_num_q;
    assign bus.rsp_data   = rsp_data_q;

`ifdef C0_RD_ARB_STATS_EN
    logic [31:0] stall_q, stall_d;

    // Count almfull cycles with pending requests, saturating
    always_comb begin
        stall_d = stall_q;
        if (bus.c0_almfull && (|bus.req_valid) && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stat_stall_cycles = stall_q;
`else
    assign stat_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_ccip_c0_rd_arbiter.sv
// Directed bench for ccip_c0_rd_arbiter with NUM_REQ=2, MAX_OUTST=4.
module tb_ccip_c0_rd_arbiter;

`ifdef C0_RD_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] stat;
    int          checks = 0;
    int          errors = 0;
    logic [511:0] pattern;

    always #5 clk = ~clk;

    ccip_c0_rd_arbiter_if #(.NUM_REQ(2)) bus ();

    ccip_c0_rd_arbiter #(.NUM_REQ(2), .MAX_OUTST(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .bus               (bus),
        .stat_stall_cycles (stat)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_valid     = '0;
        bus.req_addr      = '0;
        bus.req_len       = '0;
        bus.req_mdata     = '0;
        bus.c0_almfull    = 1'b0;
        bus.rsp_in_valid  = 1'b0;
        bus.rsp_in_mdata  = '0;
        bus.rsp_in_cl_num = '0;
        bus.rsp_in_data   = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_valid    = 2'b11;
        bus.rsp_in_valid = 1'b1;
        bus.rsp_in_mdata = 16'h1000;
        #1;
        checks++; if (bus.req_ready !== 2'b00) begin errors++;
            $display("FAIL reset_ready: got %b want 00", bus.req_ready); end
        tick(); tick();
        checks++; if (bus.c0_valid !== 1'b0) begin errors++;
            $display("FAIL reset_c0_valid: got %b want 0", bus.c0_valid); end
        checks++; if (bus.c0_addr !== 42'h0) begin errors++;
            $display("FAIL reset_c0_addr: got %h want 0", bus.c0_addr); end
        checks++; if (bus.c0_mdata !== 16'h0) begin errors++;
            $display("FAIL reset_c0_mdata: got %h want 0", bus.c0_mdata); end
        checks++; if (bus.rsp_valid !== 2'b00) begin errors++;
            $display("FAIL reset_rsp_valid: got %b want 00", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 512'h0) begin errors++;
            $display("FAIL reset_rsp_data: nonzero after reset"); end
        checks++; if (stat !== 32'd0) begin errors++;
            $display("FAIL reset_stat: got %0d want 0", stat); end
        clear_inputs();
        reset = 1'b0;
    endtask

    task automatic test_basic_grant();
        do_reset();
        bus.req_valid    = 2'b10;
        bus.req_addr[1]  = 42'h100;
        bus.req_len[1]   = 2'd0;
        bus.req_mdata[1] = 12'hABC;
        #1;
        checks++; if (bus.req_ready !== 2'b10) begin errors++;
            $display("FAIL basic_ready: got %b want 10", bus.req_ready); end
        tick();
        bus.req_valid = 2'b00;
        checks++; if (bus.c0_valid !== 1'b1) begin errors++;
            $display("FAIL basic_c0_valid: got %b want 1", bus.c0_valid); end
        checks++; if (bus.c0_addr !== 42'h100) begin errors++;
            $display("FAIL basic_c0_addr: got %h want 100", bus.c0_addr); end
        checks++; if (bus.c0_len !== 2'd0) begin errors++;
            $display("FAIL basic_c0_len: got %0d want 0", bus.c0_len); end
        checks++; if (bus.c0_mdata !== 16'h1ABC) begin errors++;
            $display("FAIL basic_c0_mdata: got %h want 1abc", bus.c0_mdata); end
        tick();
        checks++; if (bus.c0_valid !== 1'b0) begin errors++;
            $display("FAIL basic_idle_valid: got %b want 0", bus.c0_valid); end
        checks++; if (bus.c0_addr !== 42'h100) begin errors++;
            $display("FAIL basic_addr_hold: got %h want 100", bus.c0_addr); end
    endtask

    task automatic test_routing();
        pattern = {16{32'hDEADBEEF}};
        bus.rsp_in_valid  = 1'b1;
        bus.rsp_in_mdata  = 16'h1123;
        bus.rsp_in_cl_num = 2'd2;
        bus.rsp_in_data   = pattern;
        tick();
        bus.rsp_in_valid = 1'b0;
        checks++; if (bus.rsp_valid !== 2'b10) begin errors++;
            $display("FAIL route_valid: got %b want 10", bus.rsp_valid); end
        checks++; if (bus.rsp_mdata !== 12'h123) begin errors++;
            $display("FAIL route_mdata: got %h want 123", bus.rsp_mdata); end
        checks++; if (bus.rsp_cl_num !== 2'd2) begin errors++;
            $display("FAIL route_cl_num: got %0d want 2", bus.rsp_cl_num); end
        checks++; if (bus.rsp_data !== pattern) begin errors++;
            $display("FAIL route_data: got %h want %h", bus.rsp_data[31:0], pattern[31:0]); end
        tick();
        checks++; if (bus.rsp_valid !== 2'b00) begin errors++;
            $display("FAIL route_one_cycle: got %b want 00", bus.rsp_valid); end
        bus.rsp_in_valid = 1'b1;
        bus.rsp_in_mdata = 16'h5000;
        tick();
        bus.rsp_in_valid = 1'b0;
        checks++; if (bus.rsp_valid !== 2'b00) begin errors++;
            $display("FAIL route_drop: got %b want 00", bus.rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_rdy;
        logic [15:0] exp_md;
        do_reset();
        bus.req_valid    = 2'b11;
        bus.req_addr[0]  = 42'h10;
        bus.req_addr[1]  = 42'h20;
        bus.req_mdata[0] = 12'h001;
        bus.req_mdata[1] = 12'h002;
        for (int n = 0; n < 6; n++) begin
            exp_rdy = (n % 2 == 0) ? 2'b01 : 2'b10;
            exp_md  = (n % 2 == 0) ? 16'h0001 : 16'h1002;
            #1;
            checks++; if (bus.req_ready !== exp_rdy) begin errors++;
                $display("FAIL rr_ready[%0d]: got %b want %b", n, bus.req_ready, exp_rdy); end
            tick();
            checks++; if (bus.c0_valid !== 1'b1 || bus.c0_mdata !== exp_md) begin errors++;
                $display("FAIL rr_issue[%0d]: got valid=%b mdata=%h want valid=1 mdata=%h",
                         n, bus.c0_valid, bus.c0_mdata, exp_md); end
        end
        clear_inputs();
    endtask

    task automatic test_almfull();
        do_reset();
        bus.req_valid = 2'b11;
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++;
            $display("FAIL af_pre_ready: got %b want 01", bus.req_ready); end
        tick();
        bus.c0_almfull = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 2'b00) begin errors++;
            $display("FAIL af_ready: got %b want 00", bus.req_ready); end
        checks++; if (bus.c0_valid !== 1'b1) begin errors++;
            $display("FAIL af_inflight: got %b want 1", bus.c0_valid); end
        tick();
        checks++; if (bus.c0_valid !== 1'b0) begin errors++;
            $display("FAIL af_c0_drop: got %b want 0", bus.c0_valid); end
        tick(); tick();
        checks++; if (stat !== (STATS ? 32'd3 : 32'd0)) begin errors++;
            $display("FAIL af_stat: got %0d want %0d", stat, STATS ? 3 : 0); end
        bus.c0_almfull = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 2'b10) begin errors++;
            $display("FAIL af_resume: got %b want 10", bus.req_ready); end
        clear_inputs();
    endtask

    task automatic test_credit();
        do_reset();
        bus.req_valid   = 2'b01;
        bus.req_len[0]  = 2'd3;
        bus.req_addr[0] = 42'h200;
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++;
            $display("FAIL cr_first: got %b want 01", bus.req_ready); end
        tick();
        checks++; if (bus.c0_len !== 2'd3) begin errors++;
            $display("FAIL cr_len: got %0d want 3", bus.c0_len); end
        checks++; if (bus.req_ready !== 2'b00) begin errors++;
            $display("FAIL cr_full: got %b want 00", bus.req_ready); end
        bus.rsp_in_valid = 1'b1;
        bus.rsp_in_mdata = 16'h0777;
        #1;
        checks++; if (bus.req_ready !== 2'b00) begin errors++;
            $display("FAIL cr_same_cycle: got %b want 00", bus.req_ready); end
        tick();
        bus.rsp_in_valid = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 2'b00) begin errors++;
            $display("FAIL cr_len3_blocked: got %b want 00", bus.req_ready); end
        bus.req_len[0] = 2'd0;
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++;
            $display("FAIL cr_len0_ok: got %b want 01", bus.req_ready); end
        tick();
        checks++; if (bus.c0_len !== 2'd0 || bus.c0_valid !== 1'b1) begin errors++;
            $display("FAIL cr_len0_issue: got valid=%b len=%0d want 1/0",
                     bus.c0_valid, bus.c0_len); end
        checks++; if (bus.req_ready !== 2'b00) begin errors++;
            $display("FAIL cr_full_again: got %b want 00", bus.req_ready); end
        clear_inputs();
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.req_valid  = 2'b01;
        bus.req_len[0] = 2'd1;
        tick();
        // outst[0] = 2 now
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++;
            $display("FAIL sim_ready: got %b want 01", bus.req_ready); end
        bus.rsp_in_valid = 1'b1;
        bus.rsp_in_mdata = 16'h0042;
        tick();
        bus.rsp_in_valid = 1'b0;
        #1;
        // outst[0] = 3: two lines do not fit, one does
        checks++; if (bus.req_ready !== 2'b00) begin errors++;
            $display("FAIL sim_len1_blocked: got %b want 00", bus.req_ready); end
        bus.req_len[0] = 2'd0;
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++;
            $display("FAIL sim_len0_ok: got %b want 01", bus.req_ready); end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.req_valid    = 2'b11;
        bus.req_addr[0]  = 42'h3C0;
        bus.req_addr[1]  = 42'h3C4;
        bus.req_mdata[1] = 12'h055;
        bus.rsp_in_valid = 1'b1;
        bus.rsp_in_mdata = 16'h1001;
        bus.rsp_in_cl_num = 2'd1;
        bus.rsp_in_data  = {16{32'h12345678}};
        tick(); tick();
        reset = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 2'b00) begin errors++;
            $display("FAIL mid_ready_in_reset: got %b want 00", bus.req_ready); end
        tick();
        checks++; if (bus.c0_valid !== 1'b0 || bus.c0_addr !== 42'h0 ||
                      bus.c0_len !== 2'd0 || bus.c0_mdata !== 16'h0) begin errors++;
            $display("FAIL mid_c0_zero: got v=%b a=%h l=%0d m=%h want all 0",
                     bus.c0_valid, bus.c0_addr, bus.c0_len, bus.c0_mdata); end
        checks++; if (bus.rsp_valid !== 2'b00 || bus.rsp_mdata !== 12'h0 ||
                      bus.rsp_cl_num !== 2'd0 || bus.rsp_data !== 512'h0) begin errors++;
            $display("FAIL mid_rsp_zero: got v=%b m=%h c=%0d want all 0",
                     bus.rsp_valid, bus.rsp_mdata, bus.rsp_cl_num); end
        checks++; if (stat !== 32'd0) begin errors++;
            $display("FAIL mid_stat_zero: got %0d want 0", stat); end
        reset = 1'b0;
        bus.rsp_in_mdata = 16'h1000;
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++;
            $display("FAIL mid_ptr_zero: got %b want 01", bus.req_ready); end
        tick();
        // req 1 decremented at zero; must hold at 0 so four lines still fit
        bus.rsp_in_valid = 1'b0;
        bus.req_valid    = 2'b10;
        bus.req_len[1]   = 2'd3;
        #1;
        checks++; if (bus.req_ready !== 2'b10) begin errors++;
            $display("FAIL mid_no_wrap: got %b want 10", bus.req_ready); end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        pattern = '0;
        clear_inputs();
        test_reset();
        test_basic_grant();
        test_routing();
        test_round_robin();
        test_almfull();
        test_credit();
        test_simultaneous();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
